// File: rtl/scratchmem_pci_fta_gen.sv
// Pipelined FTA-bus scratchpad RAM slave with a minimal PCI-style config space (ID, mem_en, BAR0).
// Optional: define SCRATCHMEM_DECERR_EN to answer BAR misses / disabled memory with a DECERR ack.
module scratchmem_pci_fta_gen #(
  parameter int          DW               = 128,
  parameter int          DEPTH            = 32768,
  parameter int          RD_LAT           = 2,
  parameter int          TIDW             = 13,
  parameter logic [31:0] BAR0_INIT        = 32'hFFF80000,
  parameter logic [31:0] BAR0_MASK        = 32'hFFF80000,
  parameter logic [4:0]  CFG_DEVICE       = 5'd11,
  parameter logic [31:0] VENDOR_DEVICE_ID = 32'h0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cs_config_i,
  input  logic              cs_ram_i,
  input  logic              req_cyc,
  input  logic              req_stb,
  input  logic              req_we,
  input  logic [2:0]        req_cti,
  input  logic [DW/8-1:0]   req_sel,
  input  logic [31:0]       req_padr,
  input  logic [DW-1:0]     req_dat,
  input  logic [3:0]        req_cid,
  input  logic [TIDW-1:0]   req_tid,
  output logic              resp_ack,
  output logic [DW-1:0]     resp_dat,
  output logic [3:0]        resp_cid,
  output logic [TIDW-1:0]   resp_tid,
  output logic [31:0]       resp_adr,
  output logic [1:0]        resp_err,
  output logic              resp_stall
);

  localparam int        BW      = $clog2(DW / 8);
  localparam int        AW      = $clog2(DEPTH);
  localparam int        NL      = DW / 32;
  localparam logic [2:0] CTI_ERC = 3'd7;

  // Everything the response needs, carried alongside the RAM read pipeline.
  typedef struct packed {
    logic            ack;
`ifdef SCRATCHMEM_DECERR_EN
    logic            err;
`endif
    logic            cfg;
    logic [31:0]     cfg_dat;
    logic [3:0]      cid;
    logic [TIDW-1:0] tid;
    logic [31:0]     adr;
  } meta_t;

  // Stage 0: registered request
  logic            s0_csd_q;
  logic            s0_cfgd_q;
  logic            s0_we_q;
  logic            s0_erc_q;
  logic [DW/8-1:0] s0_sel_q;
  logic [31:0]     s0_adr_q;
  logic [DW-1:0]   s0_dat_q;
  logic [3:0]      s0_cid_q;
  logic [TIDW-1:0] s0_tid_q;

  // Config space state
  logic [31:0]     bar0_q;
  logic            mem_en_q;

  // Stage 1 decode results
  logic            mem_hit;
  logic            ram_we;
  logic            acc_ok;
  logic [31:0]     cfg_rd_dat;
  logic [31:0]     cfg_wdat;
  logic [AW-1:0]   ram_waddr;
  meta_t           meta_d;

  // Delay line: meta_q[0] is stage 1, meta_q[k] lines up with rd_q[k-1]
  meta_t           meta_q [RD_LAT+1];
  logic [AW-1:0]   s1_addr_q;
  logic [DW-1:0]   mem [DEPTH];
  logic [DW-1:0]   rd_q [RD_LAT];

  // Registered response
  logic            resp_ack_q;
  logic [DW-1:0]   resp_dat_q;
  logic [3:0]      resp_cid_q;
  logic [TIDW-1:0] resp_tid_q;
  logic [31:0]     resp_adr_q;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s0_csd_q  <= 1'b0;
      s0_cfgd_q <= 1'b0;
      s0_we_q   <= 1'b0;
      s0_erc_q  <= 1'b0;
      s0_sel_q  <= '0;
      s0_adr_q  <= '0;
      s0_dat_q  <= '0;
      s0_cid_q  <= '0;
      s0_tid_q  <= '0;
    end else begin
      // Config select wins over memory select, so a dual select never touches the RAM.
      s0_csd_q  <= cs_ram_i & ~cs_config_i & req_cyc & req_stb;
      s0_cfgd_q <= cs_config_i & req_cyc & req_stb &
                   (req_padr[27:20] == 8'h00) &
                   (req_padr[19:15] == CFG_DEVICE) &
                   (req_padr[14:12] == 3'h0);
      s0_we_q   <= req_we;
      s0_erc_q  <= (req_cti == CTI_ERC);
      s0_sel_q  <= req_sel;
      s0_adr_q  <= req_padr;
      s0_dat_q  <= req_dat;
      s0_cid_q  <= req_cid;
      s0_tid_q  <= req_tid;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    mem_hit   = s0_csd_q & mem_en_q & (((s0_adr_q ^ bar0_q) & BAR0_MASK) == 32'h0);
    ram_we    = mem_hit & s0_we_q;
    acc_ok    = ~s0_we_q | s0_erc_q;
    ram_waddr = s0_adr_q[BW +: AW];

    cfg_wdat = '0;
    for (int l = 0; l < NL; l++) begin
      if (s0_adr_q[BW-1:2] == l[BW-3:0]) cfg_wdat = s0_dat_q[l*32 +: 32];
    end

    case (s0_adr_q[7:2])
      6'h00:   cfg_rd_dat = VENDOR_DEVICE_ID;
      6'h01:   cfg_rd_dat = {30'h0, mem_en_q, 1'b0};
      6'h04:   cfg_rd_dat = bar0_q & BAR0_MASK;
      default: cfg_rd_dat = 32'h0;
    endcase

    meta_d         = '0;
    meta_d.ack     = (mem_hit | s0_cfgd_q) & acc_ok;
`ifdef SCRATCHMEM_DECERR_EN
    meta_d.err     = s0_csd_q & ~mem_hit;
    meta_d.ack     = meta_d.ack | meta_d.err;
`endif
    meta_d.cfg     = s0_cfgd_q;
    meta_d.cfg_dat = cfg_rd_dat;
    meta_d.cid     = s0_cid_q;
    meta_d.tid     = s0_tid_q;
    meta_d.adr     = s0_adr_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bar0_q   <= BAR0_INIT;
      mem_en_q <= 1'b1;
    end else if (s0_cfgd_q && s0_we_q) begin
      case (s0_adr_q[7:2])
        6'h01:   mem_en_q <= cfg_wdat[1];
        6'h04:   bar0_q   <= cfg_wdat & BAR0_MASK;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_addr_q <= '0;
      for (int k = 0; k <= RD_LAT; k++) meta_q[k] <= '0;
    end else begin
      s1_addr_q <= ram_waddr;
      meta_q[0] <= meta_d;
      for (int k = 1; k <= RD_LAT; k++) meta_q[k] <= meta_q[k-1];
    end
  end

  // NOTE: the RAM array and its read registers carry no reset; the valid bits in meta_q gate them.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < DW / 8; b++) begin
      if (ram_we && s0_sel_q[b]) mem[ram_waddr][b*8 +: 8] <= s0_dat_q[b*8 +: 8];
    end
    // Read is issued one cycle after the write slot, so a following read sees the new word.
    rd_q[0] <= mem[s1_addr_q];
    for (int k = 1; k < RD_LAT; k++) rd_q[k] <= rd_q[k-1];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      resp_ack_q <= 1'b0;
      resp_dat_q <= '0;
      resp_cid_q <= '0;
      resp_tid_q <= '0;
      resp_adr_q <= '0;
    end else begin
      resp_ack_q <= meta_q[RD_LAT].ack;
      resp_cid_q <= meta_q[RD_LAT].cid;
      resp_tid_q <= meta_q[RD_LAT].tid;
      resp_adr_q <= meta_q[RD_LAT].adr;
      if (meta_q[RD_LAT].cfg)
        resp_dat_q <= {NL{meta_q[RD_LAT].cfg_dat}};
`ifdef SCRATCHMEM_DECERR_EN
      else if (meta_q[RD_LAT].err)
        resp_dat_q <= '0;
`endif
      else
        resp_dat_q <= rd_q[RD_LAT-1];
    end
  end

`ifdef SCRATCHMEM_DECERR_EN
  logic [1:0] resp_err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) resp_err_q <= 2'b00;
    else       resp_err_q <= {2{meta_q[RD_LAT].err}};
  end

  assign resp_err = resp_err_q;
`else
  assign resp_err = 2'b00;
`endif

  assign resp_ack   = resp_ack_q;
  assign resp_dat   = resp_dat_q;
  assign resp_cid   = resp_cid_q;
  assign resp_tid   = resp_tid_q;
  assign resp_adr   = resp_adr_q;
  assign resp_stall = 1'b0;

endmodule

// File: tb/tb_scratchmem_pci_fta_gen.sv
// Directed scoreboard bench for scratchmem_pci_fta_gen (default parameters, RD_LAT = 2).
module tb_scratchmem_pci_fta_gen;

  localparam int          DW     = 128;
  localparam int          TIDW   = 13;
  localparam int          RD_LAT = 2;
  localparam logic [31:0] CFG    = 32'h0005_8000;

  logic              clk = 1'b0;
  logic              rst;
  logic              cs_config, cs_ram, req_cyc, req_stb, req_we;
  logic [2:0]        req_cti;
  logic [DW/8-1:0]   req_sel;
  logic [31:0]       req_padr;
  logic [DW-1:0]     req_dat;
  logic [3:0]        req_cid;
  logic [TIDW-1:0]   req_tid;
  logic              resp_ack, resp_stall;
  logic [DW-1:0]     resp_dat;
  logic [3:0]        resp_cid;
  logic [TIDW-1:0]   resp_tid;
  logic [31:0]       resp_adr;
  logic [1:0]        resp_err;

  always #5 clk = ~clk;

  scratchmem_pci_fta_gen dut (
    .clk_i(clk), .rst_i(rst), .cs_config_i(cs_config), .cs_ram_i(cs_ram),
    .req_cyc(req_cyc), .req_stb(req_stb), .req_we(req_we), .req_cti(req_cti),
    .req_sel(req_sel), .req_padr(req_padr), .req_dat(req_dat), .req_cid(req_cid),
    .req_tid(req_tid), .resp_ack(resp_ack), .resp_dat(resp_dat), .resp_cid(resp_cid),
    .resp_tid(resp_tid), .resp_adr(resp_adr), .resp_err(resp_err), .resp_stall(resp_stall)
  );

  typedef struct {
    int              due;
    logic [TIDW-1:0] tid;
    logic [3:0]      cid;
    logic [31:0]     adr;
    bit              chk;
    logic [DW-1:0]   dat;
    logic [1:0]      err;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc_cnt     = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every ack must match the oldest outstanding expectation at its due cycle.
  always @(negedge clk) begin
    if (resp_ack) begin
      if (sb.size() == 0) begin
        check("spurious_ack", {255'b0, resp_ack}, 256'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ack_cycle", cyc_cnt, e.due);
        check("resp_tid", resp_tid, e.tid);
        check("resp_cid", resp_cid, e.cid);
        check("resp_adr", resp_adr, e.adr);
        check("resp_err", resp_err, e.err);
        if (e.chk) check("resp_dat", resp_dat, e.dat);
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc_cnt) begin
      check("ack_at_due", {255'b0, resp_ack}, 256'd1);
      void'(sb.pop_front());
    end
  end

  task automatic drive(input bit cfg, input bit ram, input bit we, input bit erc,
                       input logic [15:0] sel, input logic [31:0] adr,
                       input logic [DW-1:0] dat, input logic [TIDW-1:0] tid);
    @(posedge clk); #1;
    cs_config = cfg; cs_ram = ram; req_cyc = 1'b1; req_stb = 1'b1;
    req_we = we; req_cti = erc ? 3'd7 : 3'd0; req_sel = sel;
    req_padr = adr; req_dat = dat; req_tid = tid; req_cid = tid[3:0] ^ 4'h5;
  endtask

  task automatic expect_resp(input logic [31:0] adr, input logic [TIDW-1:0] tid,
                             input bit chk, input logic [DW-1:0] dat, input logic [1:0] err);
    exp_t e;
    e.due = cyc_cnt + RD_LAT + 3;
    e.tid = tid; e.cid = tid[3:0] ^ 4'h5; e.adr = adr;
    e.chk = chk; e.dat = dat; e.err = err;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cs_config = 1'b0; cs_ram = 1'b0; req_cyc = 1'b0; req_stb = 1'b0; req_we = 1'b0;
    end
  endtask

  task automatic ram_wr(input logic [31:0] adr, input logic [DW-1:0] dat, input logic [15:0] sel,
                        input bit erc, input logic [TIDW-1:0] tid);
    drive(1'b0, 1'b1, 1'b1, erc, sel, adr, dat, tid);
    if (erc) expect_resp(adr, tid, 1'b0, '0, 2'b00);
  endtask

  task automatic ram_rd(input logic [31:0] adr, input logic [TIDW-1:0] tid, input logic [DW-1:0] edat);
    drive(1'b0, 1'b1, 1'b0, 1'b0, '1, adr, '0, tid);
    expect_resp(adr, tid, 1'b1, edat, 2'b00);
  endtask

  task automatic ram_rd_miss(input logic [31:0] adr, input logic [TIDW-1:0] tid);
    drive(1'b0, 1'b1, 1'b0, 1'b0, '1, adr, '0, tid);
`ifdef SCRATCHMEM_DECERR_EN
    expect_resp(adr, tid, 1'b1, '0, 2'b11);
`endif
  endtask

  task automatic cfg_wr(input logic [7:0] off, input logic [31:0] dw, input bit erc, input logic [TIDW-1:0] tid);
    drive(1'b1, 1'b0, 1'b1, erc, '1, CFG | {24'h0, off}, {4{dw}}, tid);
    if (erc) expect_resp(CFG | {24'h0, off}, tid, 1'b0, '0, 2'b00);
  endtask

  task automatic cfg_rd(input logic [7:0] off, input logic [TIDW-1:0] tid, input logic [31:0] edw);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '1, CFG | {24'h0, off}, '0, tid);
    expect_resp(CFG | {24'h0, off}, tid, 1'b1, {4{edw}}, 2'b00);
  endtask

  task automatic drain();
    idle(1);
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
  endtask

  logic [DW-1:0] d0, d1, w0, w2, w3;

  initial begin
    d0 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    d1 = {d0[127:8], 8'hAA};
    w0 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    w2 = 128'hDEAD_BEEF_0000_0002_CAFE_F00D_0000_0020;
    w3 = 128'h0BAD_F00D_0000_0003_1234_5678_0000_0030;
    rst = 1'b1; cs_config = 1'b0; cs_ram = 1'b0; req_cyc = 1'b0; req_stb = 1'b0;
    req_we = 1'b0; req_cti = 3'd0; req_sel = '0; req_padr = '0; req_dat = '0;
    req_cid = '0; req_tid = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ack", resp_ack, 0);
    check("rst_err", resp_err, 0);
    check("rst_dat", resp_dat, 0);
    check("rst_tid", resp_tid, 0);
    check("rst_stall", resp_stall, 0);
    @(posedge clk); #1 rst = 1'b0;

    // ERC write then read-back
    ram_wr(32'hFFF8_0010, d0, '1, 1'b1, 13'd5);
    ram_rd(32'hFFF8_0010, 13'd6, d0);
    drain();

    // Silent byte write, next-cycle read sees the merged word
    ram_wr(32'hFFF8_0010, {120'h0, 8'hAA}, 16'h0001, 1'b0, 13'd7);
    ram_rd(32'hFFF8_0010, 13'd8, d1);
    drain();

    // Preload and four back-to-back reads
    ram_wr(32'hFFF8_0000, w0, '1, 1'b1, 13'd9);
    ram_wr(32'hFFF8_0020, w2, '1, 1'b1, 13'd10);
    ram_wr(32'hFFF8_0030, w3, '1, 1'b1, 13'd11);
    ram_rd(32'hFFF8_0000, 13'd1, w0);
    ram_rd(32'hFFF8_0010, 13'd2, d1);
    ram_rd(32'hFFF8_0020, 13'd3, w2);
    ram_rd(32'hFFF8_0030, 13'd4, w3);
    drain();

    // BAR0 size probe and relocation
    cfg_rd(8'h00, 13'd20, 32'h0);
    cfg_wr(8'h10, 32'hFFFF_FFFF, 1'b1, 13'd21);
    cfg_rd(8'h10, 13'd22, 32'hFFF8_0000);
    cfg_wr(8'h10, 32'h0010_0000, 1'b0, 13'd23);
    idle(2);
    ram_rd(32'h0010_0010, 13'd24, d1);
    ram_rd_miss(32'hFFF8_0000, 13'd25);
    cfg_rd(8'h10, 13'd26, 32'h0010_0000);
    cfg_wr(8'h10, 32'hFFF8_0000, 1'b0, 13'd27);
    drain();

    // mem_en off and back on
    cfg_rd(8'h04, 13'd30, 32'h2);
    cfg_wr(8'h04, 32'h0, 1'b1, 13'd31);
    idle(2);
    ram_rd_miss(32'hFFF8_0010, 13'd32);
    cfg_rd(8'h04, 13'd33, 32'h0);
    cfg_wr(8'h04, 32'h2, 1'b0, 13'd34);
    idle(2);
    ram_rd(32'hFFF8_0010, 13'd35, d1);
    // Both selects: config wins
    drive(1'b1, 1'b1, 1'b0, 1'b0, '1, CFG | 32'h10, '0, 13'd36);
    expect_resp(CFG | 32'h10, 13'd36, 1'b1, {4{32'hFFF8_0000}}, 2'b00);
    drain();

    // Reset with two reads in flight: both dropped
    drive(1'b0, 1'b1, 1'b0, 1'b0, '1, 32'hFFF8_0010, '0, 13'd40);
    drive(1'b0, 1'b1, 1'b0, 1'b0, '1, 32'hFFF8_0020, '0, 13'd41);
    @(posedge clk); #1;
    rst = 1'b1; req_cyc = 1'b0; req_stb = 1'b0; cs_ram = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("ack_in_reset", resp_ack, 0);
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check("ack_after_reset", resp_ack, 0);
    end
    cfg_rd(8'h10, 13'd42, 32'hFFF8_0000);
    drain();

    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/scratchmem_pci_fta_gen.md
Name: scratchmem_pci_fta_gen

Overview:
- Parametrised on-chip scratchpad RAM slave for the FTA bus with a built-in minimal PCI-style config space.
- Successor to the fixed 128-bit scratchmem: data width, depth, RAM read latency and tran-id width are generic.
- Adds a writable BAR0, a memory-enable bit, and optional decode-error responses.
- Sits on the system FTA bus as boot/scratch memory.

Parameters:
- DW, 128, data width in bits; 64, 128 or 256.
- DEPTH, 32768, number of DW-bit words; power of 2.
- RD_LAT, 2, RAM read latency in cycles; 1..4.
- TIDW, 13, transaction-id width.
- BAR0_INIT, 32'hFFF80000, BAR0 reset value.
- BAR0_MASK, 32'hFFF80000, BAR0 compare mask; 1 = decoded bit.
- CFG_DEVICE, 5'd11, config-space device number, matched against padr[19:15].
- VENDOR_DEVICE_ID, 32'h0, read-only dword at config offset 0x00.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- cs_config_i  in  1  config-space select
- cs_ram_i  in  1  memory-space select
- req_cyc, req_stb, req_we  in  1 each  bus cycle, strobe, write
- req_cti  in  3  cycle type; ERC = 3'd7
- req_sel  in  DW/8  byte lane enables
- req_padr  in  32  physical byte address
- req_dat  in  DW  write data
- req_cid  in  4  core id
- req_tid  in  TIDW  transaction id
- resp_ack  out  1  response valid, one cycle
- resp_dat  out  DW  read data
- resp_cid  out  4  echoed core id
- resp_tid  out  TIDW  echoed transaction id
- resp_adr  out  32  echoed address
- resp_err  out  2  00 = OKAY, 11 = DECERR
- resp_stall  out  1  tied 0; fully pipelined

Behaviour:
- Reset is asynchronous. All resp_* outputs go to 0, all pipeline valid bits clear, BAR0 = BAR0_INIT, mem_en = 1. RAM contents are not reset.
- Stage 0, edge N: register the request.
  - csd = cs_ram_i & cyc & stb.
  - cfgd = cs_config_i & cyc & stb & padr[27:20]==0 & padr[19:15]==CFG_DEVICE & padr[14:12]==0.
- Memory hit = csd & mem_en & ((padr ^ BAR0) & BAR0_MASK)==0.
- RAM word address = padr[log2(DW/8) +: log2(DEPTH)]; upper bits ignored.
- Write, at stage 1:
  - per-byte write of lanes where sel=1, only on a memory hit.
  - A read of the same word issued at N+1 or later returns the new data. A read issued in the same cycle cannot exist.
- Response timing: the response for a request sampled at edge N appears with resp_ack=1 exactly in cycle N+RD_LAT+2, for one cycle.
  - Back-to-back requests produce back-to-back acks in issue order.
  - cid, tid and padr travel down a matching delay line.
- Ack rules:
  - Memory read hit: ack.
  - Memory write hit: ack only when cti==ERC; otherwise silent.
  - Config access: ack under the same rule (reads always, writes only when cti==ERC).
- Config space (dword offset padr[7:2]); reads return the dword replicated across all DW/32 lanes:
  - 0x00: VENDOR_DEVICE_ID, read-only.
  - 0x04: bit1 = mem_en, read/write; other bits read 0.
  - 0x10: BAR0. Writes store only bits with BAR0_MASK=1; masked bits read 0. Writing all-ones and reading back yields BAR0_MASK (size probe).
  - Other offsets read 0, ignore writes.
- Config writes take effect for requests sampled two or more cycles later.
- resp_dat on a write ack or a silent cycle: don't-care; the bench must not check it.
- cs_config_i and cs_ram_i both set: config takes priority; no RAM access.
- Reset asserted with requests in flight: all are dropped and no ack follows reset release.

Optional Feature:
- Macro SCRATCHMEM_DECERR_EN.
- Defined: csd set without a memory hit (BAR miss or mem_en=0) returns ack with resp_err=2'b11 at N+RD_LAT+2, regardless of we/cti. resp_dat = 0, no RAM write.
- Undefined: such requests are silently dropped and resp_err is constant 2'b00.

Test Plan:
- Reset, then ERC write of 0x0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 to 0xFFF80010, sel all 1s -> ack at N+4 (RD_LAT=2) with the write's tid. Read of 0xFFF80010 -> same data, ack 4 cycles after issue, tid and cid echoed.
- Byte write with sel=16'h0001, data 0xAA, to 0xFFF80010 (non-ERC) -> no ack. Next-cycle read -> low byte 0xAA, upper 15 bytes unchanged.
- Four back-to-back reads of addresses 0x00, 0x10, 0x20, 0x30 with tids 1..4 -> four consecutive acks with tids 1,2,3,4 and matching data.
- Config: write 0xFFFFFFFF to BAR0 and read back -> 0xFFF80000. Write 0x00100000, read at 0x00100000 -> hit; read at 0xFFF80000 -> miss.
- Clear mem_en via config 0x04, then read -> no ack; with SCRATCHMEM_DECERR_EN defined -> ack with resp_err=2'b11.
- Assert rst_i one cycle after issuing two reads -> resp_ack stays 0 through reset and for 8 cycles after release. BAR0 reads back 0xFFF80000.
